arena_map_writer: RTL
=====================

ARENA_MAP_WRITER -- requirements
Module: arena_map_writer

Interface
REQ-001 SHALL have parameter CLR_TILE, default 3'd0, tile code written to interior cells by init/clear sweeps.
REQ-002 SHALL have parameter WALL_TILE, default 3'd1, tile code written to border cells when border init is enabled.
REQ-003 SHALL have port i_pclk  input  1  pixel clock, sole clock.
REQ-004 SHALL have port i_rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port i_wr_valid  input  1  tile write request.
REQ-006 SHALL have port o_wr_ready  output  1  write accepted when i_wr_valid && o_wr_ready.
REQ-007 SHALL have port i_wr_addr  input  8  write cell {row[3:0], col[3:0]}.
REQ-008 SHALL have port i_wr_data  input  3  tile code to write.
REQ-009 SHALL have port i_clr  input  1  single-cycle request to re-clear the whole map.
REQ-010 SHALL have port o_busy  output  1  high while an init or clear sweep runs.
REQ-011 SHALL have port i_rd_addr  input  8  display read cell {row, col}, driven by the arena renderer.
REQ-012 SHALL have port o_rd_data  output  3  tile code at i_rd_addr, to the renderer's tile select input.

Function
REQ-013 SHALL store a 16x16 map of 3-bit tile codes (256 cells).
REQ-014 SHALL return o_rd_data with exactly 1 clock of latency after i_rd_addr; read port always active, including during sweeps.
REQ-015 SHALL implement FSM states INIT, IDLE, CLEAR.
REQ-016 INIT: entered on reset; sweep counter steps 0..255, writing one cell per clock; goes to IDLE the cycle after cell 255 is written.
REQ-017 IDLE: o_wr_ready = !i_clr; an accepted write updates the cell on the same clock edge; goes to CLEAR when i_clr=1.
REQ-018 CLEAR: same sweep as INIT (256 cycles, counter restarted at 0); goes to IDLE after cell 255.
REQ-019 o_wr_ready SHALL be 0 in INIT and CLEAR; o_busy SHALL be 1 exactly in INIT and CLEAR.
REQ-020 i_clr and i_wr_valid in the same IDLE cycle: clear wins, the write is not accepted.
REQ-021 i_clr during INIT or CLEAR SHALL be ignored; the sweep is not restarted.
REQ-022 A read and a write to the same cell in the same cycle SHALL return the old content (read-first).
REQ-023 The sweep counter SHALL be 8 bits; the end of a sweep is detected at count 255, with no wrap to a second pass.

Reset
REQ-024 On i_rst=1: state=INIT, counter=0, o_wr_ready=0, o_busy=1, o_rd_data=3'd0.
REQ-025 Reset mid-sweep or mid-write SHALL restart INIT from cell 0; a pending write is dropped.
REQ-026 Map contents are undefined until the first INIT sweep completes.

Configuration
REQ-027 Macro ARENA_BORDER_INIT_EN defined: sweeps write WALL_TILE where row or col is 0 or 15, and CLR_TILE elsewhere.
REQ-028 Macro ARENA_BORDER_INIT_EN undefined: sweeps write CLR_TILE to all 256 cells.

Structure
REQ-029 Shared package arena_pkg SHALL hold GRID_DIM=16, CELL_ADDR_W=8, TILE_W=3, the tile code constants (TILE_EMPTY=0, TILE_WALL=1, TILE_BOX=2), and the FSM state enum.
REQ-030 Storage SHALL be a sub-module arena_map_ram: 256x3 simple dual-port, synchronous write, registered read, read-first.
REQ-031 The FSM, sweep counter, border decode and write arbitration SHALL live in arena_map_writer.

Verification
REQ-032 Reset held for 2 cycles, then released -> o_busy=1 for 256 cycles, then o_busy=0 and o_wr_ready=1; read cell 8'h00 -> 3'd1 with macro, 3'd0 without; read cell 8'h55 -> 3'd0.
REQ-033 In IDLE, write addr 8'h37 data 3'd2 -> o_rd_data=3'd2 one cycle after i_rd_addr=8'h37.
REQ-034 Write 8'h37 data 3'd4 while reading 8'h37 in the same cycle -> old value 3'd2 that cycle; next read returns 3'd4.
REQ-035 i_clr=1 together with i_wr_valid=1 (addr 8'h11) -> o_wr_ready=0, 256-cycle CLEAR, afterwards 8'h11 reads 3'd0.
REQ-036 i_clr pulsed at sweep cycle 100 -> ignored; sweep ends at cycle 256 with no restart.
REQ-037 i_rst asserted at sweep cycle 128 -> INIT restarts from cell 0 and completes 256 cycles after reset release.

Source files
------------

// File: rtl/arena_pkg.sv
// Shared constants, tile codes and FSM state type for the arena map writer.
// Border-wall init is selected in arena_map_writer by the ARENA_BORDER_INIT_EN macro.
package arena_pkg;

  localparam int unsigned GRID_DIM    = 16;
  localparam int unsigned CELL_ADDR_W = 8;
  localparam int unsigned TILE_W      = 3;

  localparam logic [TILE_W-1:0] TILE_EMPTY = 3'd0;
  localparam logic [TILE_W-1:0] TILE_WALL  = 3'd1;
  localparam logic [TILE_W-1:0] TILE_BOX   = 3'd2;

  localparam logic [CELL_ADDR_W-1:0] LAST_CELL = 8'd255;
  localparam logic [3:0]             EDGE_IDX  = 4'(GRID_DIM - 1);

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StClear
  } arena_state_e;

  // Cell address is {row, col}; a border cell sits on the outer ring of the grid.
  function automatic logic is_border(logic [CELL_ADDR_W-1:0] addr);
    return (addr[7:4] == 4'd0) || (addr[7:4] == EDGE_IDX) ||
           (addr[3:0] == 4'd0) || (addr[3:0] == EDGE_IDX);
  endfunction

endpackage

// File: rtl/arena_map_ram.sv
// 256x3 simple dual-port tile store: synchronous write, registered read-first read port.
module arena_map_ram
  import arena_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [CELL_ADDR_W-1:0] waddr_i,
  input  logic [TILE_W-1:0]      wdata_i,
  input  logic [CELL_ADDR_W-1:0] raddr_i,
  output logic [TILE_W-1:0]      rdata_o
);

  localparam int unsigned Depth = 2 ** CELL_ADDR_W;

  logic [TILE_W-1:0] mem_q [Depth];
  logic [TILE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking read of the same array gives the pre-write value on a same-cell collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/arena_map_writer.sv
// Arena tile map: init/clear sweep FSM, write arbitration and a read port for the renderer.
// Define ARENA_BORDER_INIT_EN to have sweeps paint a ring of WALL_TILE around the map.
module arena_map_writer
  import arena_pkg::*;
#(
  parameter logic [TILE_W-1:0] CLR_TILE  = TILE_EMPTY,
  parameter logic [TILE_W-1:0] WALL_TILE = TILE_WALL
) (
  input  logic                   i_pclk,
  input  logic                   i_rst,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [CELL_ADDR_W-1:0] i_wr_addr,
  input  logic [TILE_W-1:0]      i_wr_data,
  input  logic                   i_clr,
  output logic                   o_busy,
  input  logic [CELL_ADDR_W-1:0] i_rd_addr,
  output logic [TILE_W-1:0]      o_rd_data
);

  arena_state_e           state_q, state_d;
  logic [CELL_ADDR_W-1:0] cnt_q, cnt_d;
  logic                   ram_we;
  logic [CELL_ADDR_W-1:0] ram_waddr;
  logic [TILE_W-1:0]      ram_wdata;
  logic [TILE_W-1:0]      sweep_tile;

`ifdef ARENA_BORDER_INIT_EN
  assign sweep_tile = is_border(cnt_q) ? WALL_TILE : CLR_TILE;
`else
  logic [TILE_W-1:0] unused_wall_tile;
  assign unused_wall_tile = WALL_TILE;
  assign sweep_tile       = CLR_TILE;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_we     = 1'b0;
    ram_waddr  = i_wr_addr;
    ram_wdata  = i_wr_data;
    o_wr_ready = 1'b0;
    o_busy     = 1'b1;
    case (state_q)
      StInit, StClear: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = sweep_tile;
        if (cnt_q == LAST_CELL) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StIdle: begin
        o_busy     = 1'b0;
        o_wr_ready = !i_clr;
        if (i_clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (i_wr_valid) begin
          ram_we = 1'b1;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
    // Reset dominates: no handshake and no RAM write while it is held.
    if (i_rst) begin
      ram_we     = 1'b0;
      o_wr_ready = 1'b0;
      o_busy     = 1'b1;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  arena_map_ram u_ram (
    .clk_i   (i_pclk),
    .rst_i   (i_rst),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (i_rd_addr),
    .rdata_o (o_rd_data)
  );

endmodule
